// File: rtl/mixpix_uart_tx_if.sv
// mixpix_uart_tx_if: valid/ready byte handshake into the UART transmitter
interface mixpix_uart_tx_if;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;
  modport master (output data_i, valid_i, input ready_o);
  modport slave  (input data_i, valid_i, output ready_o);
endinterface

// File: rtl/mixpix_uart_tx.sv
// mixpix_uart_tx: buffered 8N1 UART transmitter with a small byte FIFO
module mixpix_uart_tx #(
  parameter int CLKS_PER_BIT = 4167,
  parameter int FIFO_DEPTH   = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  mixpix_uart_tx_if.slave             bus,
  output logic                        tx_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] level_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t          state_q, state_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]     level_q, level_d;
  logic            ready_q, ready_d, tx_q, tx_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            push, pop, bit_end, has_data;
  assign push     = bus.valid_i && ready_q;
  assign bit_end  = baud_q == BW'(CLKS_PER_BIT - 1);
  assign has_data = level_q != '0;
  always_comb begin
    state_d = state_q;
    baud_d  = (state_q == IDLE || bit_end) ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (has_data) begin
          pop     = 1'b1;
          state_d = START;
          tx_d    = 1'b0;
          shift_d = mem_q[rd_q];
        end
      end
      START: if (bit_end) begin
        state_d = DATA;
        tx_d    = shift_q[0];
        bit_d   = '0;
      end
      DATA: if (bit_end) begin
        state_d = bit_q == 3'd7 ? STOP : DATA;
        tx_d    = bit_q == 3'd7 ? 1'b1 : shift_q[1];
        shift_d = shift_q >> 1;
        bit_d   = bit_q == 3'd7 ? 3'd0 : bit_q + 1'b1;
      end
      STOP: if (bit_end) begin
        bit_d = bit_q + 1'b1;
        // last stop bit: chain straight into the next frame when a byte is waiting
        if (bit_q == 3'(STOP_BITS - 1)) begin
          bit_d   = '0;
          pop     = has_data;
          state_d = has_data ? START : IDLE;
          tx_d    = !has_data;
          shift_d = has_data ? mem_q[rd_q] : shift_q;
        end
      end
      default: state_d = IDLE;
    endcase
    wr_d    = wr_q + AW'(push);
    rd_d    = rd_q + AW'(pop);
    level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
    ready_d = level_d != (AW+1)'(FIFO_DEPTH);
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      ready_q <= 1'b1;
      tx_q    <= 1'b1;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      ready_q <= ready_d;
      tx_q    <= tx_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end
  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wr_q] <= bus.data_i;
  end
  assign bus.ready_o = ready_q;
  assign tx_o        = tx_q;
  assign level_o     = level_q;
  assign busy_o      = state_q != IDLE || has_data;
endmodule

// File: tb/tb_mixpix_uart_tx.sv
// tb_mixpix_uart_tx: scoreboard bench; a line-level receiver decodes frames and checks them in order
module tb_mixpix_uart_tx;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  mixpix_uart_tx_if b0 (), b1 (), b2 ();
  logic tx0, busy0, tx1, busy1, tx2, busy2;
  logic [2:0] lvl0, lvl1, lvl2;
  mixpix_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .STOP_BITS(1)) dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(b0), .tx_o(tx0), .busy_o(busy0), .level_o(lvl0));
  mixpix_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .STOP_BITS(2)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(b1), .tx_o(tx1), .busy_o(busy1), .level_o(lvl1));
  mixpix_uart_tx #(.CLKS_PER_BIT(4167), .FIFO_DEPTH(4), .STOP_BITS(1)) dut2 (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(b2), .tx_o(tx2), .busy_o(busy2), .level_o(lvl2));

  int checks = 0, passed = 0, cyc = 0;
  logic [7:0] exp_q[$];
  int start_q[$];
  logic [2:0] lvl_h[int];
  logic rdy_h[int];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    lvl_h[cyc] = lvl0;
    rdy_h[cyc] = b0.ready_o;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic wbit(input logic [7:0] v, input int t);
    int i = t / 4;
    return i == 0 ? 1'b0 : i < 9 ? v[i-1] : 1'b1;
  endfunction

  // receiver for dut0: start bit seen at a negedge, data sampled mid-bit, stop checked
  always begin : mon
    logic [7:0] d;
    logic ok, stp;
    int n;
    @(negedge clk);
    if (!rst && tx0 === 1'b0) begin
      n = cyc;
      ok = 1;
      d = '0;
      stp = 0;
      for (int j = 1; j <= 38; j++) begin
        @(negedge clk);
        if (rst) ok = 0;
        if (j >= 6 && j <= 34 && j % 4 == 2) d[(j-6)/4] = tx0;
        if (j == 38) stp = tx0;
      end
      if (ok) begin
        start_q.push_back(n);
        chk("stop_bit", stp, 1);
        if (exp_q.size() == 0) chk("unexpected_frame", d, 32'hFFFF_FFFF);
        else chk("rx_byte", d, exp_q.pop_front());
      end
    end
  end

  task automatic push0(input logic [7:0] v, output int at);
    int w = 0;
    @(negedge clk);
    b0.data_i = v;
    b0.valid_i = 1;
    while (!b0.ready_o && w < 200) begin
      @(negedge clk);
      w++;
    end
    at = -1;
    if (w >= 200) chk("push_timeout", b0.ready_o, 1);
    else begin
      @(posedge clk);
      exp_q.push_back(v);
      #1 at = cyc;
    end
  endtask

  task automatic wait_idle0(input int budget);
    int w = 0;
    @(negedge clk);
    while (busy0 && w < budget) begin
      @(negedge clk);
      w++;
    end
    chk("reach_idle", busy0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, lows, mism, w;
    int acc[6];
    logic [7:0] v, d;
    b0.data_i = 0; b0.valid_i = 0;
    b1.data_i = 0; b1.valid_i = 0;
    b2.data_i = 0; b2.valid_i = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_tx", tx0, 1);
    chk("rst_ready", b0.ready_o, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_level", lvl0, 0);
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx0 !== 1'b1) lows++;
    end
    chk("idle_tx_low_cycles", lows, 0);

    push0(8'hAB, k);
    @(negedge clk);
    b0.valid_i = 0;
    mism = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (tx0 !== wbit(8'hAB, t)) mism++;
    end
    chk("frame_ab_wave_mism", mism, 0);
    chk("busy_before_end", busy0, 1);
    @(negedge clk);
    chk("busy_fall_k41", busy0, 0);

    start_q.delete();
    for (int i = 0; i < 6; i++) push0(8'(i + 1), acc[i]);
    @(negedge clk);
    b0.valid_i = 0;
    wait_idle0(400);
    chk("stream_lvl_first", lvl_h[acc[0]], 1);
    chk("push_pop_same_edge_lvl", lvl_h[acc[1]], 1);
    chk("stream_back_to_back_acc", acc[4] - acc[0], 4);
    chk("stream_full_lvl", lvl_h[acc[4]], 4);
    chk("stream_full_ready", rdy_h[acc[4]], 0);
    chk("stream_still_full", rdy_h[acc[0] + 40], 0);
    chk("stream_late_accept", acc[5] - acc[0], 42);
    chk("stream_frames", start_q.size(), 6);
    if (start_q.size() == 6)
      for (int i = 0; i < 6; i++) chk("stream_frame_start", start_q[i] - acc[0], 1 + 40 * i);

    push0(8'h55, k);
    push0(8'h11, w);
    push0(8'h22, w);
    @(negedge clk);
    b0.valid_i = 0;
    repeat (8) @(negedge clk);
    chk("pre_reset_tx", tx0, 0);
    rst = 1;
    @(negedge clk);
    chk("midframe_rst_tx", tx0, 1);
    chk("midframe_rst_level", lvl0, 0);
    chk("midframe_rst_busy", busy0, 0);
    chk("midframe_rst_ready", b0.ready_o, 1);
    exp_q.delete();
    rst = 0;
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx0 !== 1'b1) lows++;
    end
    chk("post_reset_silent", lows, 0);

    for (int i = 0; i < 12; i++) begin
      int g;
      v = 8'($urandom);
      push0(v, w);
      g = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 60);
      if (g > 0) begin
        @(negedge clk);
        b0.valid_i = 0;
        repeat (g - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    b0.valid_i = 0;
    wait_idle0(1000);
    chk("random_drained", exp_q.size(), 0);

    @(negedge clk);
    b1.data_i = 8'h00;
    b1.valid_i = 1;
    @(negedge clk);
    b1.data_i = 8'hFF;
    @(negedge clk);
    b1.valid_i = 0;
    w = 0;
    while (tx1 !== 1'b0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("stop2_start_seen", tx1, 0);
    mism = 0;
    for (int t = 0; t < 88; t++) begin
      if (t > 0) @(negedge clk);
      if (tx1 !== (t < 44 ? wbit(8'h00, t) : wbit(8'hFF, t - 44))) mism++;
    end
    chk("stop2_wave_mism", mism, 0);
    @(negedge clk);
    chk("stop2_busy_end", busy1, 0);
    chk("stop2_level_end", lvl1, 0);

    @(negedge clk);
    b2.data_i = 8'h0D;
    b2.valid_i = 1;
    @(negedge clk);
    b2.valid_i = 0;
    w = 0;
    while (tx2 !== 1'b0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("baud9600_start_seen", tx2, 0);
    repeat (4167 + 2083) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      d[i] = tx2;
      repeat (4167) @(negedge clk);
    end
    chk("baud9600_byte", d, 8'h0D);
    chk("baud9600_stop", tx2, 1);
    repeat (4200) @(negedge clk);
    chk("baud9600_idle", busy2, 0);
    chk("baud9600_level", lvl2, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
